eq: RTL and testbench

EQ -- requirements
Module: eq

---
 rtl/eq.sv | 78 +++++++
 tb/tb_eq.sv | 135 +++++++++++++
 2 files changed

// File: rtl/eq.sv
// Equality comparator with a registered result, saturating equal/unequal edge
// counters, a sticky mismatch flag and a toggle pulse on the registered result.
module eq #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             s,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             s_q,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] neq_cnt,
    output logic             mismatch_seen,
    output logic             changed
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             s_dly_d, s_dly_q;
    logic [CNT_W-1:0] eq_cnt_d, eq_cnt_q;
    logic [CNT_W-1:0] neq_cnt_d, neq_cnt_q;
    logic             mseen_d, mseen_q;
    logic             changed_d, changed_q;

    assign s = &(x ~^ y);

    // Next-state: reset wins, otherwise exactly one counter advances and holds at all-ones.
    always_comb begin
        s_dly_d   = s_dly_q;
        eq_cnt_d  = eq_cnt_q;
        neq_cnt_d = neq_cnt_q;
        mseen_d   = mseen_q;
        changed_d = changed_q;
        if (!rst_n) begin
            s_dly_d   = 1'b1;
            eq_cnt_d  = {CNT_W{1'b0}};
            neq_cnt_d = {CNT_W{1'b0}};
            mseen_d   = 1'b0;
            changed_d = 1'b0;
        end else begin
            s_dly_d   = s;
            changed_d = (s != s_dly_q);
            if (s) begin
                if (eq_cnt_q != CNT_MAX) begin
                    eq_cnt_d = eq_cnt_q + CNT_ONE;
                end else begin
                    eq_cnt_d = eq_cnt_q;
                end
            end else begin
                mseen_d = 1'b1;
                if (neq_cnt_q != CNT_MAX) begin
                    neq_cnt_d = neq_cnt_q + CNT_ONE;
                end else begin
                    neq_cnt_d = neq_cnt_q;
                end
            end
        end
    end

    // State registers; reset is folded into the next-state logic above.
    always_ff @(posedge clk) begin
        s_dly_q   <= s_dly_d;
        eq_cnt_q  <= eq_cnt_d;
        neq_cnt_q <= neq_cnt_d;
        mseen_q   <= mseen_d;
        changed_q <= changed_d;
    end

    assign s_q           = s_dly_q;
    assign eq_cnt        = eq_cnt_q;
    assign neq_cnt       = neq_cnt_q;
    assign mismatch_seen = mseen_q;
    assign changed       = changed_q;

endmodule

// File: tb/tb_eq.sv
// Self-checking bench for eq: a 1-bit/16-bit-counter instance and an
// 8-bit/4-bit-counter instance driven together and compared to a reference model.
module tb_eq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [0:0]  x1, y1;
    logic [7:0]  x8, y8;

    logic        s1, sq1, ms1, ch1;
    logic [15:0] eqc1, neqc1;
    logic        s8, sq8, ms8, ch8;
    logic [3:0]  eqc8, neqc8;

    int n_checks = 0;
    int n_fail   = 0;

    int  m_eqc[2];
    int  m_neqc[2];
    bit  m_sq[2];
    bit  m_ms[2];
    bit  m_ch[2];
    int  cmax[2] = '{65535, 15};

    always #5 clk = ~clk;

    eq #(.WIDTH(1), .CNT_W(16)) u_w1 (
        .clk(clk), .rst_n(rst_n), .s(s1), .x(x1), .y(y1), .s_q(sq1),
        .eq_cnt(eqc1), .neq_cnt(neqc1), .mismatch_seen(ms1), .changed(ch1)
    );

    eq #(.WIDTH(8), .CNT_W(4)) u_w8 (
        .clk(clk), .rst_n(rst_n), .s(s8), .x(x8), .y(y8), .s_q(sq8),
        .eq_cnt(eqc8), .neq_cnt(neqc8), .mismatch_seen(ms8), .changed(ch8)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour of one clock edge for instance i.
    task automatic model_edge(input int i, input bit rn, input bit eqv);
        if (!rn) begin
            m_sq[i] = 1'b1; m_eqc[i] = 0; m_neqc[i] = 0; m_ms[i] = 1'b0; m_ch[i] = 1'b0;
        end else begin
            m_ch[i] = (eqv != m_sq[i]);
            m_sq[i] = eqv;
            if (eqv) m_eqc[i] = (m_eqc[i] + 1 > cmax[i]) ? cmax[i] : m_eqc[i] + 1;
            else begin
                m_neqc[i] = (m_neqc[i] + 1 > cmax[i]) ? cmax[i] : m_neqc[i] + 1;
                m_ms[i] = 1'b1;
            end
        end
    endtask

    task automatic step(input bit rn, input logic a1, input logic b1,
                        input logic [7:0] a8, input logic [7:0] b8);
        bit e1, e8;
        rst_n = rn; x1 = a1; y1 = b1; x8 = a8; y8 = b8;
        e1 = (a1 == b1);
        e8 = (a8 == b8);
        #1;
        check_value("w1_s", {31'd0, s1}, {31'd0, e1});
        check_value("w8_s", {31'd0, s8}, {31'd0, e8});
        @(posedge clk);
        model_edge(0, rn, e1);
        model_edge(1, rn, e8);
        #1;
        check_value("w1_s_q",     {31'd0, sq1},   {31'd0, m_sq[0]});
        check_value("w1_eq_cnt",  {16'd0, eqc1},  m_eqc[0]);
        check_value("w1_neq_cnt", {16'd0, neqc1}, m_neqc[0]);
        check_value("w1_mseen",   {31'd0, ms1},   {31'd0, m_ms[0]});
        check_value("w1_changed", {31'd0, ch1},   {31'd0, m_ch[0]});
        check_value("w8_s_q",     {31'd0, sq8},   {31'd0, m_sq[1]});
        check_value("w8_eq_cnt",  {28'd0, eqc8},  m_eqc[1]);
        check_value("w8_neq_cnt", {28'd0, neqc8}, m_neqc[1]);
        check_value("w8_mseen",   {31'd0, ms8},   {31'd0, m_ms[1]});
        check_value("w8_changed", {31'd0, ch8},   {31'd0, m_ch[1]});
    endtask

    initial begin
        logic [7:0] r8;
        bit         rn;
        rst_n = 1'b0; x1 = 1'b0; y1 = 1'b0; x8 = 8'h00; y8 = 8'h00;
        @(negedge clk);

        // Truth table while held in reset: s must track inputs regardless.
        step(1'b0, 1'b0, 1'b0, 8'hA5, 8'hA5);
        step(1'b0, 1'b0, 1'b1, 8'hA5, 8'hA4);
        step(1'b0, 1'b1, 1'b0, 8'h00, 8'h80);
        step(1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF);

        // Hold equality for 5 edges after reset.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'h3C, 8'h3C);
        check_value("hold_eq_cnt5", {16'd0, eqc1}, 32'd5);

        // One mismatch then three equal cycles.
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'hA5, 8'hA4);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 8'hA5, 8'hA5);
        check_value("seq_neq1", {16'd0, neqc1}, 32'd1);
        check_value("seq_eq3",  {16'd0, eqc1},  32'd3);

        // Long equality run saturates the 4-bit counter.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 8'h5A, 8'h5A);
        check_value("sat_eq15", {28'd0, eqc8}, 32'd15);

        // Reset mid-count with inputs unequal.
        step(1'b1, 1'b0, 1'b1, 8'h01, 8'h02);
        step(1'b0, 1'b0, 1'b1, 8'h01, 8'h02);
        check_value("rst_mid_s", {31'd0, s8}, 32'd0);

        // Randomized traffic with occasional resets; the 8-bit operands favour equality.
        for (int i = 0; i < 400; i++) begin
            rn = ($urandom_range(0, 31) != 0);
            r8 = 8'($urandom);
            if ($urandom_range(0, 3) != 0)
                step(rn, 1'($urandom), 1'($urandom), r8, r8);
            else
                step(rn, 1'($urandom), 1'($urandom), r8, 8'($urandom));
        end

        // Long unequal run saturates the 4-bit neq counter.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 8'h0F, 8'hF0);
        check_value("sat_neq15", {28'd0, neqc8}, 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
